// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory: the NOP encoding used as
// power-up array content and fault filler, the default geometry, and the
// response record carried from the memory to the fetch stage.
package imem_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Default geometry: 32 words of 32 bits.
    localparam int unsigned IMEM_ADDR_W = 5;
    localparam int unsigned IMEM_DATA_W = 32;

    // One fetch response as seen by the fetch stage.
    typedef struct packed {
        logic [IMEM_DATA_W-1:0] data;
        logic                   fault;
    } imem_rsp_t;

    // Misalignment / range classification of a byte address against a memory
    // of 2^addr_w words. Kept here so the top level and any checker agree on
    // the exact rule.
    function automatic logic imem_addr_fault(input logic [31:0] byte_addr,
                                             input int unsigned addr_w);
        logic misaligned_v;
        logic out_of_range_v;
        misaligned_v   = (byte_addr[1:0] != 2'b00);
        out_of_range_v = 1'b0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (b >= addr_w + 2) begin
                out_of_range_v = out_of_range_v | byte_addr[b];
            end else begin
                out_of_range_v = out_of_range_v;
            end
        end
        return misaligned_v | out_of_range_v;
    endfunction

endpackage : imem_pkg

// File: rtl/imem_array.sv
// Instruction storage: one write port (program load) and one synchronous read
// port (fetch). A write and a read to the same word in the same cycle return
// the value being written, so a freshly loaded instruction can be fetched
// without a dead cycle. The storage itself is never reset; only the read
// register is, so a reset cannot disturb a loaded program.
module imem_array import imem_pkg::*; #(
    parameter int unsigned             ADDR_WIDTH = IMEM_ADDR_W,
    parameter int unsigned             DATA_WIDTH = IMEM_DATA_W,
    parameter logic [DATA_WIDTH-1:0]   INIT_WORD  = NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Power-up content is all NOPs so an unloaded location is harmless.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_WORD};

    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  collide_s;

    assign collide_s = wr_en_i && (wr_addr_i == rd_addr_i);

    // Next read value: bypass the write data on a same-word collision,
    // otherwise read the array; hold when no read is requested.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            if (collide_s) begin
                rd_data_d = wr_data_i;
            end else begin
                rd_data_d = mem_q[rd_addr_i];
            end
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Program load port; deliberately has no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register; reset only clears the visible output to the NOP word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= INIT_WORD;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : imem_array

// File: rtl/instruction_ram.sv
// Loadable instruction memory feeding the fetch stage.
// Fetch requests arrive as byte addresses over a valid/ready handshake and are
// answered one cycle later from a single registered response slot. The slot
// is refilled in the same cycle it is drained, so back-to-back fetches run at
// one word per cycle. A flush drops a held response while still letting a
// redirect-target request be accepted alongside it.
//
// Build option: define IMEM_FAULT_EN to flag misaligned or out-of-range
// fetches (response = NOP word with rsp_fault set, array not read). Without
// it the low two address bits and all bits above the word index are ignored,
// so addresses wrap modulo the memory depth and rsp_fault stays 0.
module instruction_ram import imem_pkg::*; #(
    parameter int unsigned           ADDR_WIDTH = IMEM_ADDR_W,
    parameter int unsigned           DATA_WIDTH = IMEM_DATA_W,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_fault,

    input  logic                  flush,

    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data
);

    logic                  rsp_valid_q;
    logic                  rsp_valid_d;
    logic                  rsp_fault_q;
    logic                  rsp_fault_d;

    logic                  accept_s;
    logic                  fault_s;
    logic                  rd_en_s;
    logic [ADDR_WIDTH-1:0] word_idx_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    assign word_idx_s = req_addr[ADDR_WIDTH+1:2];

`ifdef IMEM_FAULT_EN
    assign fault_s = imem_addr_fault(req_addr, ADDR_WIDTH);
`else
    // Byte-offset and upper bits play no part when fault checking is off.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{req_addr[1:0], req_addr[31:ADDR_WIDTH+2]};
    assign fault_s            = 1'b0;
`endif

    // The slot can take a new word when it is empty, is being drained this
    // cycle, or is being discarded by a flush.
    assign req_ready = !rsp_valid_q || rsp_ready || flush;
    assign accept_s  = req_valid && req_ready;

    // A faulting fetch never touches the array; its data comes from the NOP mux.
    assign rd_en_s   = accept_s && !fault_s;

    imem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_WORD  (NOP_WORD)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (ld_en),
        .wr_addr_i (ld_addr),
        .wr_data_i (ld_data),
        .rd_en_i   (rd_en_s),
        .rd_addr_i (word_idx_s),
        .rd_data_o (rd_data_s)
    );

    // Response slot next state: a new accept always wins (even over flush),
    // otherwise a take or a flush empties the slot, otherwise it is held.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_fault_d = rsp_fault_q;
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = fault_s;
        end else if (flush || rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_fault_d = rsp_fault_q;
        end else begin
            rsp_valid_d = rsp_valid_q;
            rsp_fault_d = rsp_fault_q;
        end
    end

    // Response slot state; reset drops any held response immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Both mux inputs are registered, so the data output is stable for the
    // whole time a response is held.
    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_data  = rsp_fault_q ? NOP_WORD : rd_data_s;

endmodule : instruction_ram

// File: tb/tb_instruction_ram.sv
// Directed, table-driven bench for instruction_ram (default geometry:
// 32 words x 32 bits). Each table row is one clock cycle: inputs driven on
// the falling edge, req_ready checked before the rising edge, registered
// outputs checked just after it. Reset behaviour is exercised by hand.
module tb_instruction_ram;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'hEA00_0093;
    localparam logic [31:0] W1  = 32'h15C0_0113;
    localparam logic [31:0] W2  = 32'h0211_6233;
    localparam logic [31:0] W3  = 32'h0211_7333;
    localparam logic [31:0] WB  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic        flush;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_ram dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    typedef struct {
        string       name;
        logic        ld_en;
        logic [4:0]  ld_addr;
        logic [31:0] ld_data;
        logic        req_valid;
        logic [31:0] req_addr;
        logic        rsp_ready;
        logic        flush;
        logic        exp_ready;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name,
                       input logic ld_en_v, input logic [4:0] ld_addr_v, input logic [31:0] ld_data_v,
                       input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                       input logic e_rdy, input logic e_val, input logic chk,
                       input logic [31:0] e_dat, input logic e_flt);
        vec_t v;
        v.name = name;        v.ld_en = ld_en_v;   v.ld_addr = ld_addr_v; v.ld_data = ld_data_v;
        v.req_valid = rv;     v.req_addr = ra;     v.rsp_ready = rr;      v.flush = fl;
        v.exp_ready = e_rdy;  v.exp_valid = e_val; v.chk_data = chk;
        v.exp_data = e_dat;   v.exp_fault = e_flt;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        ld_en     = v.ld_en;
        ld_addr   = v.ld_addr;
        ld_data   = v.ld_data;
        req_valid = v.req_valid;
        req_addr  = v.req_addr;
        rsp_ready = v.rsp_ready;
        flush     = v.flush;
        #1;
        check({v.name, ".req_ready"}, {31'd0, req_ready}, {31'd0, v.exp_ready});
        @(posedge clk);
        #1;
        check({v.name, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, v.exp_valid});
        if (v.chk_data) begin
            check({v.name, ".rsp_data"},  rsp_data, v.exp_data);
            check({v.name, ".rsp_fault"}, {31'd0, rsp_fault}, {31'd0, v.exp_fault});
        end
    endtask

    initial begin
        logic [31:0] exp_80_data;
        logic [31:0] exp_06_data;
        logic        exp_bad_fault;
        vec_t        v;

`ifdef IMEM_FAULT_EN
        exp_80_data   = NOP;
        exp_06_data   = NOP;
        exp_bad_fault = 1'b1;
`else
        exp_80_data   = W0;  // wraps to index 0
        exp_06_data   = W1;  // byte offset ignored -> index 1
        exp_bad_fault = 1'b0;
`endif

        //   name        ld  idx    data  rv  addr          rr    fl    rdy   val   chk   data         flt
        add("load0",     1'b1, 5'd0, W0,  1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 1'b0, 1'b1, NOP,         1'b0);
        add("load1",     1'b1, 5'd1, W1,  1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 1'b0, 1'b1, NOP,         1'b0);
        add("load2",     1'b1, 5'd2, W2,  1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 1'b0, 1'b1, NOP,         1'b0);
        add("load3",     1'b1, 5'd3, W3,  1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 1'b0, 1'b1, NOP,         1'b0);
        add("fetch0",    1'b0, 5'd0, 32'h0, 1'b1, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, W0,          1'b0);
        add("fetch4",    1'b0, 5'd0, 32'h0, 1'b1, 32'h4,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, W1,          1'b0);
        add("fetch8",    1'b0, 5'd0, 32'h0, 1'b1, 32'h8,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, W2,          1'b0);
        add("fetchC",    1'b0, 5'd0, 32'h0, 1'b1, 32'hC,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, W3,          1'b0);
        add("drain",     1'b0, 5'd0, 32'h0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0);
        add("stall_acc", 1'b0, 5'd0, 32'h0, 1'b1, 32'h4,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, W1,          1'b0);
        add("stall1",    1'b0, 5'd0, 32'h0, 1'b1, 32'h8,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, W1,          1'b0);
        add("stall2",    1'b0, 5'd0, 32'h0, 1'b1, 32'h8,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, W1,          1'b0);
        add("stall3",    1'b0, 5'd0, 32'h0, 1'b1, 32'h8,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, W1,          1'b0);
        add("take_acc",  1'b0, 5'd0, 32'h0, 1'b1, 32'h8,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, W2,          1'b0);
        add("drain2",    1'b0, 5'd0, 32'h0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0);
        add("bypass",    1'b1, 5'd5, WB,  1'b1, 32'h14,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, WB,          1'b0);
        add("reread5",   1'b0, 5'd0, 32'h0, 1'b1, 32'h14,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, WB,          1'b0);
        add("addr80",    1'b0, 5'd0, 32'h0, 1'b1, 32'h80,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, exp_80_data, exp_bad_fault);
        add("addr06",    1'b0, 5'd0, 32'h0, 1'b1, 32'h6,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, exp_06_data, exp_bad_fault);
        add("addr04",    1'b0, 5'd0, 32'h0, 1'b1, 32'h4,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, W1,          1'b0);
        add("preflush",  1'b0, 5'd0, 32'h0, 1'b1, 32'hC,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, W3,          1'b0);
        add("flush_req", 1'b0, 5'd0, 32'h0, 1'b1, 32'h8,    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, W2,          1'b0);
        add("hold_w2",   1'b0, 5'd0, 32'h0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, W2,          1'b0);
        add("flush_only",1'b0, 5'd0, 32'h0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0);
        add("empty",     1'b0, 5'd0, 32'h0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0);

        // Reset state, checked while rst is still asserted.
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
        flush = 1'b0; ld_en = 1'b0; ld_addr = 5'd0; ld_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.rsp_data",  rsp_data, NOP);
        check("rst.rsp_fault", {31'd0, rsp_fault}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Reset while a response is held: valid must drop without a clock edge.
        v = vecs[0];
        v.name = "pre_rst"; v.ld_en = 1'b0; v.req_valid = 1'b1; v.req_addr = 32'h0;
        v.rsp_ready = 1'b0; v.flush = 1'b0; v.exp_ready = 1'b1; v.exp_valid = 1'b1;
        v.chk_data = 1'b1; v.exp_data = W0; v.exp_fault = 1'b0;
        apply(v);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("async_rst.rsp_data",  rsp_data, NOP);
        check("async_rst.req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // The array survives reset.
        v.name = "post_rst"; v.rsp_ready = 1'b1;
        apply(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instruction_ram

// File: doc/instruction_ram.md
# instruction_ram

Parametrised, synchronous, loadable instruction memory that feeds the fetch stage. It accepts byte-addressed fetch requests over a valid/ready handshake and returns one instruction word per accepted request, one cycle later, through a registered response slot. A side-band load port lets the testbench or a boot loader write the program at run time. Optionally, the block flags misaligned and out-of-range fetches. A `flush` input discards a held response when the fetch stage redirects.

## Interface
- `ADDR_WIDTH`, 5: word-index bits; depth = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: instruction width in bits.
- `NOP_WORD`, 32'h0000_0013: returned on fault and used as the initial array content (`addi x0,x0,0`).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: fetch request present.
- `req_ready` out 1: request slot can accept.
- `req_addr` in 32: byte address of the instruction.
- `rsp_valid` out 1: response slot holds a word.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_data` out DATA_WIDTH: fetched instruction.
- `rsp_fault` out 1: fetch was misaligned or out of range.
- `flush` in 1: discard the held response.
- `ld_en` in 1: write enable of the load port.
- `ld_addr` in ADDR_WIDTH: word index to write.
- `ld_data` in DATA_WIDTH: word to write.

## Operation
- Word index = `req_addr[ADDR_WIDTH+1:2]`.
- Array contents start as `NOP_WORD` at time zero. `rst` never modifies the array.
- Accept condition: `req_valid && req_ready`.
- `req_ready = !rsp_valid || rsp_ready`. This is a combinational pass-through of `rsp_ready`, giving full throughput of one word per cycle.
- An accepted request loads the response register with data, fault and `rsp_valid=1` on the next edge.
- If the slot is held (`rsp_valid && !rsp_ready`), `rsp_data` and `rsp_fault` stay stable until taken.
- A response is taken with no new accept → `rsp_valid` clears on the next edge.
- `flush=1`:
  - Clears the held response on the next edge.
  - A request accepted in the same cycle is not killed; its response appears normally. This lets the redirect target be issued together with the flush.
  - `req_ready` is forced to 1 while `flush=1`.
- Load port:
  - `ld_en` writes `ld_data` to `ld_addr` on the edge. It is independent of the fetch handshake.
  - Collision rule: if a load and a fetch hit the same index in the same cycle, the response returns the new `ld_data` (write-through bypass).
- Fault (when compiled in):
  - Causes: `req_addr[1:0]!=0`, or any `req_addr[31:ADDR_WIDTH+2]` bit set.
  - Effect: response carries `rsp_data=NOP_WORD` and `rsp_fault=1`.
  - The array is not read. The handshake is unchanged.

## Timing
- Reset values: `rsp_valid=0`, `rsp_data=NOP_WORD`, `rsp_fault=0`. `req_ready=1` while `rst` is asserted and after it deasserts.
- Latency: request accepted at edge N → `rsp_valid=1` with data after edge N.
- Back-to-back accepts with `rsp_ready=1` produce one response per cycle.
- Reset mid-operation: the held response is dropped asynchronously. A load in progress at reset assertion is not guaranteed to complete.

## Configuration
- Macro: `IMEM_FAULT_EN`.
- Defined: misalignment and range checks active as described.
- Undefined:
  - `rsp_fault` tied to 0.
  - `req_addr[1:0]` ignored.
  - Upper address bits ignored, so addresses wrap modulo depth.

## Structure
- Package `imem_pkg`:
  - `NOP_INSTR` constant (default for `NOP_WORD`).
  - Response struct typedef `imem_rsp_t` {data, fault}.
- Sub-module `imem_array`:
  - Storage, single write port plus synchronous read port, with the write-through bypass.
  - The top level holds the handshake, fault logic and response register.

## Test plan
- Reset, then load words 0..3 = 0xEA000093, 0x15C00113, 0x02116233, 0x02117333; fetch 0x0, 0x4, 0x8, 0xC back-to-back with `rsp_ready=1` → those four words on four consecutive cycles, each one cycle after accept, `rsp_fault=0`.
- Fetch 0x4 with `rsp_ready=0` for 3 cycles → `rsp_data=0x15C00113` held stable, `req_ready=0`; raise `rsp_ready` → taken, and the next request is accepted that same cycle.
- Same-cycle `ld_en` to index 5 with 0xDEADBEEF and fetch 0x14 → response 0xDEADBEEF.
- With `IMEM_FAULT_EN`:
  - Fetch 0x6 → `rsp_data=0x00000013`, `rsp_fault=1`.
  - Fetch 0x80 (depth 32) → same.
  - Without the macro, fetch 0x80 → word at index 0.
- Held response plus `flush=1` and a new request to 0x8 in the same cycle → old response dropped, next response is 0x02116233.
- Assert `rst` while `rsp_valid=1` → `rsp_valid` falls immediately (asynchronously); after release, fetch 0x0 still returns 0xEA000093 because the array is retained.
